// File: rtl/stud_audiodac_pkg.sv
// Shared constants and helpers for the audio DAC path (modulator and sinc2 decimator).
package stud_audiodac_pkg;

  localparam int unsigned BITWIDTH_DEFAULT = 16;
  localparam int unsigned OSR_LOG2_DEFAULT = 8;

  // Decimation events swallowed after reset while the comb delays fill.
  localparam logic [1:0] WARMUP_EVENTS = 2'd2;

  function automatic int unsigned cic_width(input int unsigned osr_log2);
    return 2 * osr_log2 + 1;
  endfunction

  // Clamp the comb output to full scale, then keep the top bitwidth bits.
  function automatic logic [31:0] sat_align(input logic [63:0]  c2,
                                            input int unsigned  osr_log2,
                                            input int unsigned  bitwidth);
    logic [63:0] full_scale;
    logic [63:0] clamped;
    full_scale = (64'd1 << (2 * osr_log2)) - 64'd1;
    if (c2 > full_scale) begin
      clamped = full_scale;
    end else begin
      clamped = c2;
    end
    return 32'(clamped >> (2 * osr_log2 - bitwidth));
  endfunction

endpackage

// File: rtl/stud_cic_integrator.sv
// Wrapping accumulator with enable; one CIC integrator stage.
module stud_cic_integrator
  import stud_audiodac_pkg::*;
#(
  parameter int unsigned W = cic_width(OSR_LOG2_DEFAULT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] addend,
  output logic [W-1:0] sum
);

  logic [W-1:0] acc_r;

  // Accumulate modulo 2^W on enabled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= acc_r + addend;
    end
  end

  assign sum = acc_r;

endmodule

// File: rtl/stud_sinc2_decimator.sv
// Second-order CIC decimator: 1-bit unsigned delta-sigma stream in, BITWIDTH-bit PCM out.
module stud_sinc2_decimator
  import stud_audiodac_pkg::*;
#(
  parameter int unsigned BITWIDTH = BITWIDTH_DEFAULT,
  parameter int unsigned OSR_LOG2 = OSR_LOG2_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                strobe_i,
  input  logic                mod_i,
  output logic [BITWIDTH-1:0] data_o,
  output logic                valid_o
);

  localparam int unsigned W = cic_width(OSR_LOG2);
  localparam logic [OSR_LOG2-1:0] CNT_LAST = '1;

  generate
    if (2 * OSR_LOG2 < BITWIDTH) begin : g_bad_params
      $error("stud_sinc2_decimator: 2*OSR_LOG2 must be >= BITWIDTH");
    end
  endgenerate

  logic [W-1:0]        mod_ext_s;
  logic [W-1:0]        i1_s;
  logic [W-1:0]        i2_s;
  logic [W-1:0]        c1_s;
  logic [W-1:0]        c2_s;
  logic [BITWIDTH-1:0] pcm_s;
  logic                event_s;

  logic [OSR_LOG2-1:0] cnt_r;
  logic [1:0]          warm_r;
  logic [W-1:0]        d1_r;
  logic [W-1:0]        d2_r;
  logic [BITWIDTH-1:0] data_r;
  logic                valid_r;

  stud_cic_integrator #(.W(W)) u_int1 (
    .clk    (clk_i),
    .rst    (rst_i),
    .en     (strobe_i),
    .addend (mod_ext_s),
    .sum    (i1_s)
  );

  // Second stage adds the first stage's pre-edge value.
  stud_cic_integrator #(.W(W)) u_int2 (
    .clk    (clk_i),
    .rst    (rst_i),
    .en     (strobe_i),
    .addend (i1_s),
    .sum    (i2_s)
  );

  // Comb differences are taken on the pre-edge i2; wrap-around cancels exactly.
  always_comb begin
    mod_ext_s = {{(W-1){1'b0}}, mod_i};
    event_s   = strobe_i && (cnt_r == CNT_LAST);
    c1_s      = i2_s - d1_r;
    c2_s      = c1_s - d2_r;
    pcm_s     = BITWIDTH'(sat_align(64'(c2_s), OSR_LOG2, BITWIDTH));
  end

  // Phase counter, comb delays, warm-up gating and registered output stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r   <= '0;
      warm_r  <= 2'd0;
      d1_r    <= '0;
      d2_r    <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (strobe_i) begin
        cnt_r <= cnt_r + OSR_LOG2'(1);
      end
      if (event_s) begin
        d1_r <= i2_s;
        d2_r <= c1_s;
        if (warm_r == WARMUP_EVENTS) begin
          data_r  <= pcm_s;
          valid_r <= 1'b1;
        end else begin
          warm_r <= warm_r + 2'd1;
        end
      end
    end
  end

  assign data_o  = data_r;
  assign valid_o = valid_r;

endmodule

// File: tb/tb_stud_sinc2_decimator.sv
// Scoreboard bench: triangular-window reference model against the sinc2 decimator.
module tb_stud_sinc2_decimator;

  localparam int BW   = 16;
  localparam int L    = 8;
  localparam int N    = 1 << L;
  localparam int FULL = (1 << (2 * L)) - 1;

  typedef struct {
    int unsigned stamp;
    logic [BW-1:0] data;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          strobe;
  logic          mod;
  logic [BW-1:0] data_o;
  logic          valid_o;

  int unsigned edge_cnt = 0;
  int          vectors = 0;
  int          miscompares = 0;
  bit          run = 0;
  logic        rst_d = 1'b1;
  logic        prev_valid = 1'b0;
  logic [BW-1:0] exp_data = '0;

  exp_t exp_q[$];
  bit   hist[$];
  int   phase = 0;
  int   warm = 0;
  logic [15:0] lb_acc = 16'd0;

  stud_sinc2_decimator #(.BITWIDTH(BW), .OSR_LOG2(L)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .strobe_i (strobe),
    .mod_i    (mod),
    .data_o   (data_o),
    .valid_o  (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    edge_cnt = edge_cnt + 1;
    rst_d <= rst;
  end

  // Output = triangle-weighted sum of accepted bits; the newest bit before the
  // decimation edge and the edge's own bit carry zero weight.
  function automatic logic [BW-1:0] model_out();
    int s = 0;
    int len = hist.size();
    for (int d = 1; d < 2 * N; d++) begin
      int idx = len - 1 - d;
      int w = (d <= N) ? d : (2 * N - d);
      if (idx >= 0 && hist[idx]) s += w;
    end
    if (s > FULL) s = FULL;
    return BW'(s >> (2 * L - BW));
  endfunction

  task automatic step(input bit r, input bit s, input bit m);
    @(negedge clk);
    rst = r;
    strobe = s;
    mod = m;
    if (r) begin
      hist.delete();
      phase = 0;
      warm = 0;
    end else if (s) begin
      if (phase == N - 1) begin
        if (warm >= 2) begin
          exp_t e;
          e.stamp = edge_cnt + 1;
          e.data = model_out();
          exp_q.push_back(e);
        end else begin
          warm++;
        end
      end
      hist.push_back(m);
      if (hist.size() > 2 * N) void'(hist.pop_front());
      phase = (phase + 1) % N;
    end
  endtask

  task automatic lb_step(input logic [15:0] word);
    logic [16:0] sum;
    sum = {1'b0, lb_acc} + {1'b0, word};
    step(1'b0, 1'b1, sum[16]);
    lb_acc = sum[15:0];
  endtask

  // Monitor: pops expectations when the DUT presents a word; checks hold and reset.
  always @(negedge clk) begin
    if (run) begin
      if (rst_d) begin
        exp_data = '0;
        vectors++;
        if (valid_o !== 1'b0) begin
          miscompares++;
          $display("FAIL reset_valid: valid_o=%b required 0 at edge %0d", valid_o, edge_cnt);
        end
      end else if (valid_o === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL spurious_valid: data_o=%h with no expected word at edge %0d", data_o, edge_cnt);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          exp_data = e.data;
          if (e.stamp != edge_cnt || data_o !== e.data) begin
            miscompares++;
            $display("FAIL output_word: got %h at edge %0d, required %h at edge %0d",
                     data_o, edge_cnt, e.data, e.stamp);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].stamp <= edge_cnt) begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing_valid: valid_o=%b, required 1 with %h at edge %0d", valid_o, e.data, e.stamp);
      end
      vectors++;
      if (data_o !== exp_data) begin
        miscompares++;
        $display("FAIL data_hold: data_o=%h required %h at edge %0d", data_o, exp_data, edge_cnt);
      end
      if (prev_valid === 1'b1 && valid_o === 1'b1) begin
        miscompares++;
        $display("FAIL valid_width: valid_o high on consecutive cycles at edge %0d", edge_cnt);
      end
      prev_valid = valid_o;
    end
  end

  initial begin
    rst = 1'b1;
    strobe = 1'b0;
    mod = 1'b0;
    @(posedge clk);
    #1 run = 1;
    step(1'b1, 1'b0, 1'b0);

    // All zeros, continuous strobe.
    for (int i = 0; i < 6 * N; i++) step(1'b0, 1'b1, 1'b0);

    // All ones.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6 * N; i++) step(1'b0, 1'b1, 1'b1);

    // Alternating, both phases.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5 * N; i++) step(1'b0, 1'b1, 1'(i % 2));
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5 * N; i++) step(1'b0, 1'b1, 1'((i + 1) % 2));

    // Strobe pattern 1,0,0 with all-ones input.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12 * N + 6; i++) step(1'b0, 1'((i % 3) == 0), 1'b1);

    // Random bits with random strobe gaps.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8 * N; i++) step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom));

    // Loopback 0x4000 with a one-cycle reset at phase 100.
    step(1'b1, 1'b0, 1'b0);
    lb_acc = 16'd0;
    for (int i = 0; i < 4 * N + 100; i++) lb_step(16'h4000);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5 * N; i++) lb_step(16'h4000);

    // Loopback 0xC000.
    step(1'b1, 1'b0, 1'b0);
    lb_acc = 16'd0;
    for (int i = 0; i < 6 * N; i++) lb_step(16'hC000);

    // Reset coinciding with a decimation edge must not produce a word.
    for (int i = 0; i < N - 1; i++) lb_step(16'hC000);
    step(1'b1, 1'b1, 1'b1);

    // Drain and confirm no expected output went unseen.
    for (int i = 0; i < 2 * N; i++) step(1'b0, 1'b0, 1'b0);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected words never presented, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stud_sinc2_decimator.md
# stud_sinc2_decimator

Second-order CIC (sinc²) decimator that turns a 1-bit delta-sigma bitstream back into unsigned PCM words. It is the receive-side counterpart of the first-order modulator: feeding modulator output back in reconstructs the modulator's input word. It is used for loopback self-test of the audio DAC path and for decoding external PDM/ΔΣ streams. It sits between the bitstream source and the PCM consumer.

## Interface
- `BITWIDTH`, 16: output PCM width; unsigned, same format as the modulator input.
- `OSR_LOG2`, 8: log2 of the decimation ratio, OSR = 2^OSR_LOG2. Constraint: 2·OSR_LOG2 ≥ BITWIDTH, checked at elaboration.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  **synchronous, active-high reset.**
- `strobe_i`  in  1  sample qualifier; `mod_i` is consumed only on cycles where it is high.
- `mod_i`  in  1  bitstream input; 1 → +1, 0 → 0 (unsigned mapping).
- `data_o`  out  BITWIDTH  decoded PCM word; held between updates.
- `valid_o`  out  1  one-cycle pulse marking a new `data_o`.

## Operation
- Internal width W = 2·OSR_LOG2 + 1. All integrator and comb arithmetic is modulo 2^W; wrap-around is intended and exact.
- **Integrators**, on each strobed cycle:
  - i1 ← i1 + mod_i
  - i2 ← i2 + i1, using the pre-edge value of i1.
- **Phase counter** `cnt` (OSR_LOG2 bits):
  - increments on each strobed cycle;
  - wraps OSR-1 → 0.
- **Decimation event**: a strobed edge with `cnt == OSR-1`. At that edge:
  - c1 = i2 − d1, then d1 ← i2 (pre-edge i2);
  - c2 = c1 − d2, then d2 ← c1.
- **Output scaling**:
  - c2 ranges over 0..2^(2·OSR_LOG2);
  - saturate to 2^(2·OSR_LOG2) − 1;
  - take the top BITWIDTH bits (right-shift by 2·OSR_LOG2 − BITWIDTH) into `data_o`.
- **Warm-up**:
  - a 2-bit counter suppresses `valid_o` and the `data_o` update for the first 2 decimation events after reset;
  - the comb delays still update during warm-up;
  - every later event updates `data_o` and pulses `valid_o`.
- `strobe_i` low: integrators, counter, combs and warm-up counter all hold. `valid_o` is still deasserted on the next cycle.

## Timing
- **Reset values**: `data_o` = 0, `valid_o` = 0. Internally, i1, i2, d1, d2, `cnt` and the warm-up counter are all 0.
- **Reset mid-operation** discards all state, including a pending output. Counting restarts exactly as after power-up.
- `valid_o` is high only for the cycle immediately after a qualifying decimation edge. It is never high two consecutive cycles; with OSR ≥ 2 it is structurally impossible.
- `data_o` changes only on the edge that raises `valid_o`.
- **Continuous strobe, first valid**: decimation edges occur at cycle indices OSR−1, 2·OSR−1, 3·OSR−1 after reset release. The first `valid_o` is therefore seen in cycle 3·OSR.
- **Steady-state period**: OSR strobed cycles per output.
- **Filter memory**: each output is the triangular-weighted sum of the last 2·OSR−1 accepted bits. Bits sampled on the decimation edge itself are excluded because i2 is taken pre-edge.
- **Simultaneous events**: reset together with a decimation edge means reset wins, with no `valid_o`. `strobe_i` low on what would be the decimation cycle delays the event to the next strobed cycle.

## Structure
- Package `stud_audiodac_pkg` holds:
  - the width function W(OSR_LOG2);
  - the warm-up count constant (2);
  - the saturation and alignment helper function.
  - The modulator reuses the same `BITWIDTH` default from this package.
- One natural sub-module, `stud_cic_integrator`: a W-bit accumulator with enable, instantiated twice.
- Combs, counter and output stage stay in the top module.

## Test plan
- **All zeros**: `mod_i` = 0 continuous, strobe = 1 → first `valid_o` at cycle 3·OSR (768 for the default OSR_LOG2 = 8), `data_o` = 0x0000, then one pulse every 256 cycles.
- **All ones**: `mod_i` = 1 → `data_o` = 0xFFFF (saturated from 0x10000) on every valid output.
- **Alternating**: `mod_i` = 1,0,1,0… in either phase → `data_o` = 0x8000 exactly on every valid output.
- **Loopback**: first-order modulator driven with `data_i` = 0x4000, and separately 0xC000, its output fed to `mod_i` → steady-state `data_o` = 0x4000 (respectively 0xC000) exactly.
- **Strobe gaps**: `strobe_i` pattern 1,0,0 with all-ones input → first `valid_o` after 768 strobed cycles (2304 clocks), value 0xFFFF. `valid_o` lasts exactly one cycle and is not stretched by strobe.
- **Reset mid-run**: assert `rst_i` for 1 cycle at cnt = 100 of a loopback run → `data_o` = 0 and `valid_o` = 0 next cycle, next `valid_o` exactly 768 cycles after release, value 0x4000.
